// File: rtl/apb_obi_pkg.sv
// Shared types and helpers for the APB-to-OBI bridge: FSM state encoding and
// the address window check.
package apb_obi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Widened to 64 bits so base+size cannot wrap for any 32-bit window.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && (addr < (base + size));
  endfunction

endpackage

// File: rtl/apb_to_obi_bridge.sv
// APB completer that turns each APB transfer into one OBI transaction, with an
// address window check and sticky OBI handshake parity checking.
module apb_to_obi_bridge
  import apb_obi_pkg::*;
#(
  parameter int          APB_AW   = 32,
  parameter int          APB_DW   = 32,
  parameter int          OBI_AW   = 32,
  parameter int          OBI_DW   = 32,
  parameter int          OBI_IDW  = 1,
  parameter logic [31:0] WIN_BASE = 32'h0100_0000,
  parameter logic [31:0] WIN_SIZE = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [APB_AW-1:0]     APB_PADDR,
  input  logic                  APB_PSEL,
  input  logic                  APB_PENABLE,
  input  logic                  APB_PWRITE,
  input  logic [APB_DW-1:0]     APB_PWDATA,
  input  logic [APB_DW/8-1:0]   APB_PSTRB,
  output logic [APB_DW-1:0]     APB_PRDATA,
  output logic                  APB_PREADY,
  output logic                  APB_PSLVERR,
  output logic                  obi_req,
  output logic                  obi_reqpar,
  output logic [OBI_AW-1:0]     obi_addr,
  output logic                  obi_we,
  output logic [OBI_DW/8-1:0]   obi_be,
  output logic [OBI_DW-1:0]     obi_wdata,
  output logic [OBI_IDW-1:0]    obi_aid,
  output logic                  obi_rready,
  output logic                  obi_rreadypar,
  input  logic                  obi_gnt,
  input  logic                  obi_gntpar,
  input  logic                  obi_rvalid,
  input  logic                  obi_rvalidpar,
  input  logic [OBI_DW-1:0]     obi_rdata,
  input  logic                  obi_err,
  input  logic [OBI_IDW-1:0]    obi_rid,
  output logic                  obi_par_err
);

  state_e                state_q, state_d;
  logic [OBI_AW-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [OBI_DW/8-1:0]   be_q, be_d;
  logic [OBI_DW-1:0]     wdata_q, wdata_d;
  logic [APB_DW-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  req_q, req_d;
  logic                  rready_q, rready_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  par_err_q, par_err_d;
  logic                  setup;

  // Only a setup phase starts a transfer; PSEL+PENABLE seen in IDLE is ignored.
  assign setup = APB_PSEL && !APB_PENABLE;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = OBI_AW'(APB_PADDR);
          we_d    = APB_PWRITE;
          be_d    = APB_PWRITE ? APB_PSTRB : '1;
          wdata_d = APB_PWDATA;
          if (in_window(64'(APB_PADDR), 64'(WIN_BASE), 64'(WIN_SIZE))) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_REQ: begin
        if (obi_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (obi_rvalid) begin
          rdata_d = we_q ? '0 : obi_rdata;
          err_d   = obi_err || (obi_rid != '0);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_d     = (state_d == S_REQ);
    rready_d  = (state_d == S_RESP);
    pready_d  = (state_d == S_DONE);
    pslverr_d = (state_d == S_DONE) && err_d;
    par_err_d = par_err_q || (obi_gntpar == obi_gnt) || (obi_rvalidpar == obi_rvalid);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      rready_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      req_q     <= req_d;
      rready_q  <= rready_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      par_err_q <= par_err_d;
    end
  end

  assign obi_req       = req_q;
  assign obi_reqpar    = ~req_q;
  assign obi_rready    = rready_q;
  assign obi_rreadypar = ~rready_q;
  assign obi_addr      = addr_q;
  assign obi_we        = we_q;
  assign obi_be        = be_q;
  assign obi_wdata     = wdata_q;
  assign obi_aid       = '0;
  assign APB_PRDATA    = rdata_q;
  assign APB_PREADY    = pready_q;
  assign APB_PSLVERR   = pslverr_q;
  assign obi_par_err   = par_err_q;

endmodule

// File: doc/apb_to_obi_bridge.md
# apb_to_obi_bridge

APB completer that converts each APB transfer into a single OBI transaction on an OBI manager port. It is the reverse of the OBI-to-APB splitter path. A subsystem's APB-facing logic can use it to reach OBI targets such as SRAM or system control. It supports one outstanding transfer and an address window check, and it checks OBI handshake parity.

## Interface
Parameters:
- APB_AW, 32, APB address width
- APB_DW, 32, APB data width (equals OBI_DW)
- OBI_AW, 32, OBI address width
- OBI_DW, 32, OBI data width
- OBI_IDW, 1, OBI ID width
- WIN_BASE, 32'h0100_0000, first accepted address
- WIN_SIZE, 32'h0001_0000, window size in bytes; accepted range is [WIN_BASE, WIN_BASE+WIN_SIZE)

Ports:
- clk  in  1  clock; one clock domain
- reset_n  in  1  reset; synchronous, active-low
- APB_PADDR  in  APB_AW  APB address
- APB_PSEL  in  1  select
- APB_PENABLE  in  1  access phase
- APB_PWRITE  in  1  write=1
- APB_PWDATA  in  APB_DW  write data
- APB_PSTRB  in  APB_DW/8  write strobes
- APB_PRDATA  out  APB_DW  read data
- APB_PREADY  out  1  transfer complete
- APB_PSLVERR  out  1  transfer error
- obi_req, obi_reqpar  out  1 each  request; reqpar = ~req
- obi_addr  out  OBI_AW  APB_PADDR zero-extended or truncated
- obi_we  out  1  write enable
- obi_be  out  OBI_DW/8  PSTRB on writes, all ones on reads
- obi_wdata  out  OBI_DW  write data
- obi_aid  out  OBI_IDW  constant 0
- obi_rready, obi_rreadypar  out  1 each  response ready; rreadypar = ~rready
- obi_gnt, obi_gntpar  in  1 each  grant and its parity
- obi_rvalid, obi_rvalidpar  in  1 each  response valid and its parity
- obi_rdata  in  OBI_DW  read data
- obi_err  in  1  response error
- obi_rid  in  OBI_IDW  response ID
- obi_par_err  out  1  sticky parity-mismatch flag

## Operation
- FSM has four states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- IDLE:
  - Leaves IDLE when APB_PSEL=1 and APB_PENABLE=0 (setup phase).
  - On that cycle it latches PADDR, PWRITE, PWDATA and PSTRB.
  - In window: go to REQ.
  - Out of window: go to DONE with err_q=1 and rdata_q=0. No OBI activity occurs.
- REQ:
  - obi_req=1; address and write-data signals come from the latched registers and are stable until grant.
  - obi_gnt=1: go to RESP.
  - req is never withdrawn before gnt.
- RESP:
  - obi_rready=1.
  - obi_rvalid=1: capture rdata_q (only when the transfer is a read; otherwise rdata_q=0).
  - Set err_q = obi_err OR (obi_rid != 0).
  - Go to DONE.
- DONE:
  - APB_PREADY=1 and APB_PSLVERR=err_q for exactly one cycle, then go to IDLE.
  - This cycle coincides with the APB access phase.
- APB_PREADY=0 in every state except DONE, which stretches the access phase with wait states.
- APB_PRDATA is driven from rdata_q, which holds its value until the next capture.
- Parity:
  - In every cycle, obi_gntpar != ~obi_gnt or obi_rvalidpar != ~obi_rvalid sets obi_par_err.
  - Only reset clears obi_par_err.
  - obi_par_err does not affect the FSM.
- An OBI request is never issued for APB_PSEL=1, APB_PENABLE=1 seen in IDLE (a protocol violation). The FSM stays in IDLE.

## Timing
- Reset values: obi_req=0, obi_reqpar=1, obi_rready=0, obi_rreadypar=1, obi_addr/obi_wdata/obi_be/obi_we=0, APB_PREADY=0, APB_PSLVERR=0, APB_PRDATA=0, obi_par_err=0, state IDLE.
- Reset asserted mid-transfer: on the next clk edge all outputs take reset values, including dropping obi_req. This is legal only because the OBI fabric shares reset_n.
- Minimum in-window latency, counted from the setup cycle T0:
  - T1: REQ, with gnt in the same cycle.
  - T2: RESP, with rvalid in the same cycle.
  - T3: DONE, APB_PREADY=1.
- Each gnt or rvalid stall cycle adds one cycle.
- Out-of-window: APB_PREADY=1 at T1.
- Back-to-back: a new setup phase can be accepted in the cycle after DONE.

## Structure
- Shared package apb_obi_pkg: the state enum (IDLE/REQ/RESP/DONE, 2 bits) and a window-check function in_window(addr, base, size).
- Single flat module; no sub-module needed.

## Test plan
- Read in window: PADDR=0x0100_0010, gnt at T1, rvalid at T2 with rdata=0xDEADBEEF -> obi_addr=0x0100_0010, be=4'hF, we=0; PREADY=1 at T3, PRDATA=0xDEADBEEF, PSLVERR=0.
- Write with stalls: PWDATA=0x1234_5678, PSTRB=4'b0011, gnt held off 3 cycles, rvalid 2 cycles after gnt -> obi_req held with stable addr and wdata; be=4'b0011; PREADY=1 exactly 1 cycle, at T0+7.
- Out-of-window: PADDR=0x0200_0000 -> obi_req stays 0; PREADY=1 and PSLVERR=1 at T1; PRDATA=0.
- Error responses: obi_err=1 -> PSLVERR=1. Separately, obi_rid=1 with err=0 -> PSLVERR=1.
- Parity: one cycle with obi_gntpar=obi_gnt -> obi_par_err=1 from the next cycle until reset; the transfer still completes normally.
- Reset in REQ: reset_n=0 for 1 cycle while obi_req=1 -> obi_req=0 next cycle, state IDLE; a following read completes normally.
